// File: rtl/vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG Avalon readback path.
package vjtag_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam logic [1:0]  AVALON_BYTEENABLE_ALL = 2'b11;
    localparam int unsigned JTAG_SYNC_STAGES      = 2;

endpackage

// File: rtl/vjtag_word_fifo.sv
// Synchronous show-ahead word FIFO with flush; push and pop in one cycle are both honoured.
module vjtag_word_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A pop from a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/vjtag_mm_read.sv
// Avalon-MM block reader feeding a word FIFO, serialised LSB-first onto virtual-JTAG TDO.
module vjtag_mm_read
    import vjtag_pkg::*;
#(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] BaseAddress,
    input  logic [CNT_W-1:0]  WordCount,
    input  logic              JTAG_TCK,
    input  logic              JTAG_Capture,
    input  logic              JTAG_Shift,
    output logic              TDO,
    output logic              Avalon_ChipEnable,
    output logic [1:0]        Avalon_ByteEnable,
    output logic              Avalon_Write,
    output logic [DATA_W-1:0] Avalon_WriteData,
    output logic [ADDR_W-1:0] Avalon_Address,
    output logic              Avalon_Read,
    input  logic              Avalon_WaitRequest,
    input  logic [DATA_W-1:0] Avalon_ReadData,
    input  logic              Avalon_ReadDataValid,
    output logic              Busy,
    output logic              Underrun
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W  = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    // JTAG strobe synchronisers; TCK carries one extra stage for edge detection.
    logic [2:0]                  tck_sync_q;
    logic [JTAG_SYNC_STAGES-1:0] cap_sync_q;
    logic [JTAG_SYNC_STAGES-1:0] shift_sync_q;
    logic                        cap_prev_q;
    logic                        tck_fall;
    logic                        cap_rise;
    logic                        shift_on;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [FCNT_W-1:0]   outstanding_q, outstanding_d;
    logic                aborted_q, aborted_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                underrun_q, underrun_d;

    logic                start_ok;
    logic                accept;
    logic                ret;
    logic                rd_room;
    logic                fifo_flush;
    logic                fifo_push;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_data;
    logic [FCNT_W-1:0]   fifo_count;
    logic                fifo_empty;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tck_sync_q   <= '0;
            cap_sync_q   <= '0;
            shift_sync_q <= '0;
            cap_prev_q   <= 1'b0;
        end else begin
            tck_sync_q   <= {tck_sync_q[1:0], JTAG_TCK};
            cap_sync_q   <= {cap_sync_q[JTAG_SYNC_STAGES-2:0], JTAG_Capture};
            shift_sync_q <= {shift_sync_q[JTAG_SYNC_STAGES-2:0], JTAG_Shift};
            cap_prev_q   <= cap_sync_q[JTAG_SYNC_STAGES-1];
        end
    end

    assign tck_fall = !tck_sync_q[1] && tck_sync_q[2];
    assign cap_rise = cap_sync_q[JTAG_SYNC_STAGES-1] && !cap_prev_q;
    assign shift_on = shift_sync_q[JTAG_SYNC_STAGES-1];

    // Buffered words plus in-flight reads may never exceed the FIFO capacity.
    assign rd_room     = (32'(fifo_count) + 32'(outstanding_q)) < 32'(FIFO_DEPTH);
    assign Avalon_Read = (state_q == StFetch) && (remaining_q != '0) && rd_room;
    assign accept      = Avalon_Read && !Avalon_WaitRequest;
    assign ret         = Avalon_ReadDataValid && (state_q != StIdle) && (outstanding_q != '0);
    assign fifo_push   = ret && !aborted_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        aborted_d     = aborted_q;
        fifo_flush    = 1'b0;
        start_ok      = 1'b0;

        if (accept) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end
        if (accept && !ret) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && ret) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (Start && (WordCount != '0)) begin
                    state_d       = StFetch;
                    addr_d        = BaseAddress;
                    remaining_d   = WordCount;
                    outstanding_d = '0;
                    aborted_d     = 1'b0;
                    fifo_flush    = 1'b1;
                    start_ok      = 1'b1;
                end
            end
            StFetch: begin
                if (Abort) begin
                    state_d   = StDrain;
                    aborted_d = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (Abort) begin
                    aborted_d = 1'b1;
                end
                if (outstanding_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;

        if (start_ok) begin
            underrun_d = 1'b0;
        end

        if (cap_rise) begin
            idx_d = '0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shreg_d  = fifo_data;
            end else begin
                shreg_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (tck_fall && shift_on) begin
            if (idx_q == LAST_IDX) begin
                // Word boundary: the next word replaces the shift instead of following it.
                idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_data;
                end else begin
                    shreg_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            aborted_q     <= 1'b0;
            shreg_q       <= '0;
            idx_q         <= '0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            aborted_q     <= aborted_d;
            shreg_q       <= shreg_d;
            idx_q         <= idx_d;
            underrun_q    <= underrun_d;
        end
    end

    vjtag_word_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (Avalon_ReadData),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign TDO               = shreg_q[0];
    assign Avalon_Address    = addr_q;
    assign Avalon_ChipEnable = 1'b1;
    assign Avalon_ByteEnable = AVALON_BYTEENABLE_ALL;
    assign Avalon_Write      = 1'b0;
    assign Avalon_WriteData  = '0;
    assign Busy              = (state_q != StIdle);
    assign Underrun          = underrun_q;

endmodule
